richard28277_alu_core: RTL and testbench
========================================

// Module: richard28277_alu_core
// PURPOSE
//   Registered 4-bit ALU core of the Tiny Tapeout tile tt_um_Richard28277.
//   Two nibble operands arrive on ui_in and a 4-bit opcode arrives on uio_in[3:0].
//   An 8-bit result drives uo_out; status flags drive uio_out[7:4].
//   The TT top wrapper instantiates this core and ties rst = ~rst_n; the core's own ports are given below.
// PARAMETERS
//   DATA_W   4   operand width; the pin map supports only 4
// PORTS
//   clk      in   1  single clock, rising edge
//   rst      in   1  synchronous, active-high reset
//   ena      in   1  tile enable; 0 = hold all registers
//   ui_in    in   8  [3:0]=A, [7:4]=B (both unsigned)
//   uio_in   in   8  [3:0]=opcode, [7:4] ignored
//   uo_out   out  8  registered result
//   uio_out  out  8  [4]=C, [5]=Z, [6]=V, [7]=E; [3:0] always 0
//   uio_oe   out  8  constant 8'hF0
// BEHAVIOUR
//   - Reset: synchronous, active-high; rst=1 at a rising edge clears result and flags to 0.
//     rst takes priority over ena. uio_oe stays 8'hF0 during reset.
//   - Latency 1: inputs are sampled at a clock edge when ena=1; the new result and flags are visible right after that edge.
//   - ena=0: result and flags hold their values.
//   - Opcodes (R = next uo_out):
//     0 ADD  R={3'b0,C,S}, S=(A+B)[3:0], C=carry out
//     1 SUB  R={4'b0,(A-B)[3:0]}, C=borrow (A<B)
//     2 MUL  R=A*B (full 8 bit)
//     3 DIV  R={A%B,A/B}; if B==0 then R=8'hFF, E=1
//     4 AND  5 OR  6 XOR: R={4'b0,A op B}
//     7 NOT  R={4'b0,~A}
//     8 SHL  R=A<<B[2:0] (8-bit result, zero fill)
//     9 SHR  R={4'b0,A>>B[1:0]}
//     10 CMP R={5'b0,A>B,A==B,A<B}
//     11..15 illegal: R=0, E=1
//   - Flags:
//     C is defined only for ADD and SUB; it is 0 for all other opcodes.
//     V = signed overflow, treating A and B as 4-bit two's complement; ADD and SUB only, 0 otherwise.
//     Z = (R==8'h00); this includes the illegal-opcode case.
//     E = divide by zero or illegal opcode; 0 otherwise.
//   - No multi-cycle operations: every opcode, including DIV, is combinational before the register.
// STRUCTURE
//   - Package richard28277_pkg: opcode localparams OP_ADD..OP_CMP and flag bit indices F_C=4, F_Z=5, F_V=6, F_E=7.
//   - Sub-module richard28277_alu_comb: purely combinational; inputs A, B, op; outputs R[7:0] and flags[3:0].
//   - The core holds an 8-bit result register and a 4-bit flag register, plus the constant uio_oe.
// TESTING
//   - Reset: rst=1 for 2 clocks with random inputs -> uo_out=0, uio_out=0, uio_oe=F0.
//   - ADD: A=9, B=8, op=0 -> uo_out=8'h11, C=1, V=1, Z=0, one cycle later.
//   - SUB: A=3, B=5, op=1 -> uo_out=8'h0E, C=1. Also A=5, B=5 -> uo_out=0, Z=1.
//   - MUL and DIV:
//       A=F, B=F, op=2 -> 8'hE1.
//       A=D, B=4, op=3 -> 8'h13.
//       B=0, op=3 -> 8'hFF, E=1.
//   - ena and illegal opcode:
//       ena=0 while inputs change -> outputs hold.
//       op=12 with ena=1 -> uo_out=0, Z=1, E=1.
//   - Exhaustive sweep of A, B and every opcode against a reference model; also rst asserted mid-stream clears on the next edge.

Source files
------------

// File: rtl/richard28277_pkg.sv
// Shared opcodes, widths and flag positions for the Richard28277 ALU tile.
package richard28277_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned FLAG_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_MUL = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV = 4'd3;
    localparam logic [OP_W-1:0] OP_AND = 4'd4;
    localparam logic [OP_W-1:0] OP_OR  = 4'd5;
    localparam logic [OP_W-1:0] OP_XOR = 4'd6;
    localparam logic [OP_W-1:0] OP_NOT = 4'd7;
    localparam logic [OP_W-1:0] OP_SHL = 4'd8;
    localparam logic [OP_W-1:0] OP_SHR = 4'd9;
    localparam logic [OP_W-1:0] OP_CMP = 4'd10;

    // Flag bit positions on uio_out; the flag register holds bits [7:4].
    localparam int unsigned F_C      = 4;
    localparam int unsigned F_Z      = 5;
    localparam int unsigned F_V      = 6;
    localparam int unsigned F_E      = 7;
    localparam int unsigned FLAG_LSB = 4;

endpackage

// File: rtl/richard28277_alu_comb.sv
// Purely combinational 4-bit ALU datapath: result and {E,V,Z,C} flags.
module richard28277_alu_comb
    import richard28277_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [OP_W-1:0]   i_op,
    output logic [RES_W-1:0]  o_r,
    output logic [FLAG_W-1:0] o_flags
);

    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [RES_W-1:0]  w_prod;
    logic              w_b_nz;
    logic [DATA_W-1:0] w_div_b;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;
    logic [RES_W-1:0]  w_shl;
    logic [DATA_W-1:0] w_shr;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod  = RES_W'(i_a) * RES_W'(i_b);
    assign w_b_nz  = (i_b != '0);
    // Divisor forced to 1 when B is zero so the divider never sees x/0.
    assign w_div_b = w_b_nz ? i_b : DATA_W'(1);
    assign w_quot  = i_a / w_div_b;
    assign w_rem   = i_a % w_div_b;
    assign w_shl   = {4'b0, i_a} << i_b[2:0];
    assign w_shr   = i_a >> i_b[1:0];

    // Opcode decode and flag generation.
    always_comb begin
        o_r     = '0;
        o_flags = '0;
        unique case (i_op)
            OP_ADD: begin
                o_r = {3'b0, w_sum};
                o_flags[F_C-FLAG_LSB] = w_sum[DATA_W];
                o_flags[F_V-FLAG_LSB] = (i_a[3] == i_b[3]) && (w_sum[3] != i_a[3]);
            end
            OP_SUB: begin
                o_r = {4'b0, w_diff[DATA_W-1:0]};
                o_flags[F_C-FLAG_LSB] = w_diff[DATA_W];
                o_flags[F_V-FLAG_LSB] = (i_a[3] != i_b[3]) && (w_diff[3] != i_a[3]);
            end
            OP_MUL: o_r = w_prod;
            OP_DIV: begin
                if (w_b_nz) begin
                    o_r = {w_rem, w_quot};
                end else begin
                    o_r = 8'hFF;
                    o_flags[F_E-FLAG_LSB] = 1'b1;
                end
            end
            OP_AND: o_r = {4'b0, i_a & i_b};
            OP_OR:  o_r = {4'b0, i_a | i_b};
            OP_XOR: o_r = {4'b0, i_a ^ i_b};
            OP_NOT: o_r = {4'b0, ~i_a};
            OP_SHL: o_r = w_shl;
            OP_SHR: o_r = {4'b0, w_shr};
            OP_CMP: o_r = {5'b0, i_a > i_b, i_a == i_b, i_a < i_b};
            default: o_flags[F_E-FLAG_LSB] = 1'b1;
        endcase
        o_flags[F_Z-FLAG_LSB] = (o_r == '0);
    end

endmodule

// File: rtl/richard28277_alu_core.sv
// Registered ALU core: one-cycle latency, enable hold, synchronous reset.
module richard28277_alu_core
    import richard28277_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [RES_W-1:0]  r_result;
    logic [FLAG_W-1:0] r_flags;
    logic [RES_W-1:0]  w_r;
    logic [FLAG_W-1:0] w_flags;
    logic              w_unused;

    // Upper uio_in bits carry no function in this tile.
    assign w_unused = ^uio_in[7:4];

    richard28277_alu_comb u_alu (
        .i_a     (ui_in[3:0]),
        .i_b     (ui_in[7:4]),
        .i_op    (uio_in[3:0]),
        .o_r     (w_r),
        .o_flags (w_flags)
    );

    // Result/flag registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (ena) begin
            r_result <= w_r;
            r_flags  <= w_flags;
        end
    end

    assign uo_out  = r_result;
    assign uio_out = {r_flags, 4'b0};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_richard28277_alu_core.sv
// Self-checking bench for richard28277_alu_core against an arithmetic reference model.
module tb_richard28277_alu_core;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
    bit         model_ok = 0;

    richard28277_alu_core dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: returns {E,V,Z,C,R[7:0]} from plain integer arithmetic.
    function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
        int r, sa, sb, t;
        bit c, v, z, e;
        r = 0; c = 0; v = 0; e = 0;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        case (op)
            0: begin r = a + b; c = (r > 15); t = sa + sb; v = (t > 7) || (t < -8); end
            1: begin r = (a - b + 16) % 16; c = (a < b); t = sa - sb; v = (t > 7) || (t < -8); end
            2: r = a * b;
            3: if (b == 0) begin r = 255; e = 1; end else r = (a % b) * 16 + a / b;
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            7: r = 15 - a;
            8: r = (a << (b % 8)) % 256;
            9: r = a >> (b % 4);
            10: r = (a > b ? 4 : 0) + (a == b ? 2 : 0) + (a < b ? 1 : 0);
            default: begin r = 0; e = 1; end
        endcase
        z = (r == 0);
        return {e, v, z, c, 8'(r)};
    endfunction

    // Model update at each edge, then compare once outputs have settled.
    always @(posedge clk) begin
        logic [11:0] m;
        if (rst) begin
            exp_uo   = 8'h00;
            exp_uio  = 8'h00;
            model_ok = 1;
        end else if (ena && model_ok) begin
            m       = ref_alu(int'(ui_in[3:0]), int'(ui_in[7:4]), int'(uio_in[3:0]));
            exp_uo  = m[7:0];
            exp_uio = {m[11:8], 4'b0};
        end
        #2;
        if (model_ok) begin
            total++;
            if (uo_out !== exp_uo || uio_out !== exp_uio || uio_oe !== 8'hF0) begin
                bad++;
                $display("FAIL model t=%0t uo_out=%h want %h uio_out=%h want %h uio_oe=%h want f0",
                         $time, uo_out, exp_uo, uio_out, exp_uio, uio_oe);
            end
        end
    end

    task automatic step(input logic [7:0] ui, input logic [7:0] uio, input logic e, input logic r);
        ui_in  = ui;
        uio_in = uio;
        ena    = e;
        rst    = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [7:0] w_uo, input logic [7:0] w_uio);
        total++;
        if (uo_out !== w_uo || uio_out !== w_uio || uio_oe !== 8'hF0) begin
            bad++;
            $display("FAIL %s uo_out=%h want %h uio_out=%h want %h uio_oe=%h want f0",
                     name, uo_out, w_uo, uio_out, w_uio, uio_oe);
        end
    endtask

    task automatic pin_model(input string name, input int a, input int b, input int op,
                             input logic [11:0] want);
        logic [11:0] got;
        got = ref_alu(a, b, op);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s model=%h want %h", name, got, want);
        end
    endtask

    initial begin
        pin_model("pin_add", 9, 8, 0, 12'h511);
        pin_model("pin_div", 13, 4, 3, 12'h013);
        pin_model("pin_mul", 15, 15, 2, 12'h0E1);
        pin_model("pin_ill", 1, 2, 12, 12'hA00);

        // Reset for two clocks with random inputs.
        step(8'($urandom), 8'($urandom), 1'b1, 1'b1);
        step(8'($urandom), 8'($urandom), 1'b1, 1'b1);
        lit("reset", 8'h00, 8'h00);

        step({4'd8, 4'd9}, 8'd0, 1'b1, 1'b0);
        lit("add_9_8", 8'h11, 8'h50);
        step({4'd5, 4'd3}, 8'd1, 1'b0, 1'b0);
        lit("ena_hold", 8'h11, 8'h50);
        step({4'd1, 4'd7}, 8'd2, 1'b0, 1'b0);
        lit("ena_hold2", 8'h11, 8'h50);
        step({4'd5, 4'd3}, 8'd1, 1'b1, 1'b0);
        lit("sub_3_5", 8'h0E, 8'h10);
        step({4'd5, 4'd5}, 8'd1, 1'b1, 1'b0);
        lit("sub_5_5", 8'h00, 8'h20);
        step({4'hF, 4'hF}, 8'd2, 1'b1, 1'b0);
        lit("mul_f_f", 8'hE1, 8'h00);
        step({4'd4, 4'hD}, 8'd3, 1'b1, 1'b0);
        lit("div_d_4", 8'h13, 8'h00);
        step({4'd0, 4'd7}, 8'd3, 1'b1, 1'b0);
        lit("div_by0", 8'hFF, 8'h80);
        step({4'd3, 4'd6}, 8'd12, 1'b1, 1'b0);
        lit("illegal", 8'h00, 8'hA0);
        step({4'd3, 4'd6}, 8'd2, 1'b1, 1'b0);
        lit("mul_6_3", 8'h12, 8'h00);
        step({4'd3, 4'd6}, 8'd2, 1'b1, 1'b1);
        lit("mid_rst", 8'h00, 8'h00);

        // Exhaustive sweep of every opcode and operand pair.
        for (int op = 0; op < 16; op++)
            for (int b = 0; b < 16; b++)
                for (int a = 0; a < 16; a++)
                    step({4'(b), 4'(a)}, {4'($urandom), 4'(op)}, 1'b1, 1'b0);

        // Random mix of enable, reset and ignored upper uio bits.
        for (int i = 0; i < 600; i++)
            step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
